seq_decode_counter: RTL and testbench
=====================================

// Module: seq_decode_counter
// PURPOSE
//  Parametrised successor to the 4-bit decoder counter. Generates binary, Gray, Johnson or
//  ring sequences with up/down count, programmable terminal value, synchronous load and
//  one-hot decode of the sequence index. Drives sequence-generator and strobe-select logic.
// PARAMETERS
//  WIDTH  4          code / index width; legal range 2..8
//  DEC_W  2**WIDTH   decode width (derived; do not override)
// PORTS
//  clk       in   1       rising-edge clock
//  rst       in   1       synchronous active-high reset
//  enable    in   1       advance one step per clk while high
//  up_dn     in   1       1 = increment index, 0 = decrement index
//  mode      in   2       0 binary, 1 Gray, 2 Johnson, 3 ring
//  limit     in   WIDTH   terminal index for binary/Gray modes (LAST = limit)
//  load      in   1       synchronous load of load_val into the index
//  load_val  in   WIDTH   index to load
//  count     out  WIDTH   sequence code for the current index
//  decode    out  DEC_W   one-hot of the current index (bit idx set)
//  wrap      out  1       one-cycle pulse: index wrapped on the last step
//  load_err  out  1       one-cycle pulse: load_val > LAST was rejected
// BEHAVIOUR
//  - Single clock; reset is synchronous and active-high. The state is the index register
//    idx plus registered mode_q, wrap and load_err.
//  - LAST: binary/Gray = limit; Johnson = 2*WIDTH-1; ring = WIDTH-1.
//  - Reset: idx=0, mode_q=mode, wrap=0, load_err=0. Outputs during reset: count=0
//    (ring mode: count=1), decode=1.
//  - Per-cycle priority: rst > load > mode change (mode != mode_q) > enable > hold.
//  - Load: if load_val <= LAST, set idx=load_val. Otherwise set idx=0 and pulse load_err
//    for 1 cycle. A load never asserts wrap.
//  - Mode change: set idx=0 and mode_q=mode. No wrap. The step requested in that cycle is lost.
//  - Enable, up (up_dn=1): if idx >= LAST, set idx=0 and wrap=1. Otherwise idx+1.
//  - Enable, down (up_dn=0): if idx==0, set idx=LAST and wrap=1. If idx > LAST, set
//    idx=LAST with no wrap. Otherwise idx-1.
//  - limit=0: idx stays at 0. wrap pulses on every enabled cycle.
//  - limit is not registered. A reduction below idx takes effect on the next enabled step
//    per the rules above.
//  - wrap and load_err are registered. They are high in the same cycle that count/decode
//    first show the new index. They are low in every cycle without such an event.
//  - count and decode are combinational from idx and mode_q, so there is zero added latency.
//    Code map:
//      binary  = idx
//      Gray    = idx ^ (idx>>1)
//      Johnson = thermometer pattern of step idx: 0000,0001,0011,0111,1111,1110,1100,1000
//      ring    = 1<<idx
//  - enable=0 holds idx. No pulses are generated.
// STRUCTURE
//  - Package seq_gen_pkg: MODE_BIN/MODE_GRAY/MODE_JOHN/MODE_RING localparams and the
//    last_idx() function.
//  - Sub-module seq_code_map: combinational (idx, mode) -> count.
//  - Top level: index FSM, decode generation and pulse registers.
// TESTING  (WIDTH=4)
//  - rst=1 for 2 cycles -> count=0, decode=16'h0001, wrap=0, load_err=0.
//  - mode=0, limit=9, up, enable 12 cycles -> count 1..9,0,1,2. wrap is high only in the
//    cycle where count=0.
//  - mode=1, limit=15, load 4'd7, then 1 up step -> count 4'b0100 then 4'b1100.
//    decode goes 0x0080 -> 0x0100.
//  - mode=2, down from idx 0 -> idx=7 with count=4'b1000 and wrap=1. Next step gives
//    idx=6, count=4'b1100.
//  - mode=0, limit=5, load 4'd9 -> idx=0 and load_err=1 for exactly 1 cycle.
//    load and enable together -> the load wins.
//  - mode=3 at idx=2 after a switch from mode 0 -> count=4'b0001, no wrap.
//    Assert rst mid-count -> idx=0 on the next edge.

Source files
------------

// File: rtl/seq_gen_pkg.sv
// ---------------------------------------------------------------------------
// seq_gen_pkg
//   Shared definitions for the sequence/decode counter:
//   - MODE_* encodings of the 2-bit mode input
//   - act_e: the action the index register takes in a given cycle
//   - last_idx(): terminal index for a mode, limit and code width
// ---------------------------------------------------------------------------
package seq_gen_pkg;

    localparam logic [1:0] MODE_BIN  = 2'd0;
    localparam logic [1:0] MODE_GRAY = 2'd1;
    localparam logic [1:0] MODE_JOHN = 2'd2;
    localparam logic [1:0] MODE_RING = 2'd3;

    // One action per cycle, chosen by priority load > mode change > step > hold.
    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_LOAD,
        ACT_MODE,
        ACT_UP,
        ACT_DOWN
    } act_e;

    // Terminal index. Computed on 8 bits (the widest legal WIDTH); callers
    // truncate to their own width. Johnson's 2*width-1 always fits in width bits
    // for width >= 2.
    function automatic logic [7:0] last_idx(input logic [1:0] mode,
                                            input logic [7:0] limit,
                                            input int unsigned width);
        logic [7:0] res;
        case (mode)
            MODE_BIN,
            MODE_GRAY: res = limit;
            MODE_JOHN: res = 8'(2 * width - 1);
            default:   res = 8'(width - 1);
        endcase
        return res;
    endfunction

endpackage

// File: rtl/seq_code_map.sv
// ---------------------------------------------------------------------------
// seq_code_map
//   Combinational map from sequence index to output code.
//   Ports:
//     idx   in  WIDTH  current sequence index
//     mode  in  2      code type (binary, Gray, Johnson, ring)
//     count out WIDTH  code for idx in the selected mode
// ---------------------------------------------------------------------------
module seq_code_map
    import seq_gen_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] idx,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONES  = '1;
    localparam logic [WIDTH-1:0] W_IDX = WIDTH'(WIDTH);

    always_comb begin
        count = '0;
        case (mode)
            MODE_BIN:  count = idx;
            MODE_GRAY: count = idx ^ (idx >> 1);
            MODE_JOHN: begin
                // Fill phase sets idx low bits; drain phase clears low bits.
                if (idx <= W_IDX) begin
                    count = ~(ONES << idx);
                end else begin
                    count = ONES << (idx - W_IDX);
                end
            end
            default:   count = WIDTH'(1) << idx;
        endcase
    end

endmodule

// File: rtl/seq_decode_counter.sv
// ---------------------------------------------------------------------------
// seq_decode_counter
//   Binary / Gray / Johnson / ring sequence generator with up/down stepping,
//   programmable terminal index, synchronous load and one-hot index decode.
//   Ports:
//     clk       in   1      rising-edge clock
//     rst       in   1      synchronous active-high reset
//     enable    in   1      step once per clock while high
//     up_dn     in   1      1 = increment, 0 = decrement
//     mode      in   2      0 binary, 1 Gray, 2 Johnson, 3 ring
//     limit     in   WIDTH  terminal index for binary/Gray
//     load      in   1      load load_val into the index
//     load_val  in   WIDTH  index to load
//     count     out  WIDTH  code for the current index
//     decode    out  DEC_W  one-hot of the current index
//     wrap      out  1      pulse: index wrapped on the last step
//     load_err  out  1      pulse: load_val beyond the terminal index rejected
// ---------------------------------------------------------------------------
module seq_decode_counter
    import seq_gen_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEC_W = 2 ** WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             up_dn,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] limit,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic [DEC_W-1:0] decode,
    output logic             wrap,
    output logic             load_err
);

    logic [WIDTH-1:0] idx;
    logic [WIDTH-1:0] idx_nxt;
    logic [1:0]       mode_q;
    logic [1:0]       mode_q_nxt;
    logic             wrap_nxt;
    logic             load_err_nxt;
    logic [WIDTH-1:0] last;
    act_e             act;

    // Terminal index follows the registered mode; limit is used live.
    assign last = WIDTH'(last_idx(mode_q, 8'(limit), WIDTH));

    always_comb begin
        act = ACT_HOLD;
        if (load) begin
            act = ACT_LOAD;
        end else if (mode != mode_q) begin
            act = ACT_MODE;
        end else if (enable) begin
            act = up_dn ? ACT_UP : ACT_DOWN;
        end
    end

    always_comb begin
        idx_nxt      = idx;
        mode_q_nxt   = mode_q;
        wrap_nxt     = 1'b0;
        load_err_nxt = 1'b0;
        case (act)
            ACT_LOAD: begin
                if (load_val <= last) begin
                    idx_nxt = load_val;
                end else begin
                    idx_nxt      = '0;
                    load_err_nxt = 1'b1;
                end
            end
            ACT_MODE: begin
                idx_nxt    = '0;
                mode_q_nxt = mode;
            end
            ACT_UP: begin
                // >= also catches an index stranded above a lowered limit.
                if (idx >= last) begin
                    idx_nxt  = '0;
                    wrap_nxt = 1'b1;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
            ACT_DOWN: begin
                if (idx == '0) begin
                    idx_nxt  = last;
                    wrap_nxt = 1'b1;
                end else if (idx > last) begin
                    idx_nxt = last;
                end else begin
                    idx_nxt = idx - 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            mode_q   <= mode;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            idx      <= idx_nxt;
            mode_q   <= mode_q_nxt;
            wrap     <= wrap_nxt;
            load_err <= load_err_nxt;
        end
    end

    seq_code_map #(
        .WIDTH (WIDTH)
    ) u_code_map (
        .idx   (idx),
        .mode  (mode_q),
        .count (count)
    );

    assign decode = DEC_W'(1) << idx;

endmodule

// File: tb/tb_seq_decode_counter.sv
module tb_seq_decode_counter;

    localparam int W = 4;
    localparam int D = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic         up_dn;
    logic [1:0]   mode;
    logic [W-1:0] limit;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] count;
    logic [D-1:0] decode;
    logic         wrap;
    logic         load_err;

    int errors = 0;
    int checks = 0;

    // Reference state: index, mode in force, and the pulses of the last edge.
    int m_idx;
    int m_mode;
    int m_wrap;
    int m_lerr;

    always #5 clk = ~clk;

    seq_decode_counter #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .up_dn    (up_dn),
        .mode     (mode),
        .limit    (limit),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .decode   (decode),
        .wrap     (wrap),
        .load_err (load_err)
    );

    function automatic int last_of(int md, int lim);
        if (md == 0 || md == 1) return lim;
        if (md == 2) return 2 * W - 1;
        return W - 1;
    endfunction

    function automatic int code_of(int md, int i);
        int full;
        full = (1 << W) - 1;
        case (md)
            0: return i;
            1: return i ^ (i >> 1);
            2: begin
                if (i <= W) return (1 << i) - 1;
                return full - ((1 << (i - W)) - 1);
            end
            default: return (1 << i) & full;
        endcase
    endfunction

    task automatic model_step();
        int last;
        last   = last_of(m_mode, int'(limit));
        m_wrap = 0;
        m_lerr = 0;
        if (rst) begin
            m_idx  = 0;
            m_mode = int'(mode);
        end else if (load) begin
            if (int'(load_val) <= last) m_idx = int'(load_val);
            else begin
                m_idx  = 0;
                m_lerr = 1;
            end
        end else if (int'(mode) != m_mode) begin
            m_idx  = 0;
            m_mode = int'(mode);
        end else if (enable) begin
            if (up_dn) begin
                if (m_idx >= last) begin
                    m_idx  = 0;
                    m_wrap = 1;
                end else m_idx = m_idx + 1;
            end else begin
                if (m_idx == 0) begin
                    m_idx  = last;
                    m_wrap = 1;
                end else if (m_idx > last) m_idx = last;
                else m_idx = m_idx - 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"},    32'(count),    32'(code_of(m_mode, m_idx)));
        chk({tag, ".decode"},   32'(decode),   32'(1 << m_idx));
        chk({tag, ".wrap"},     32'(wrap),     32'(m_wrap));
        chk({tag, ".load_err"}, 32'(load_err), 32'(m_lerr));
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; up_dn = 1'b1; mode = 2'd0;
        limit = 4'd9; load = 1'b0; load_val = '0;
        m_idx = 0; m_mode = 0; m_wrap = 0; m_lerr = 0;

        // Reset
        tick("rst1");
        tick("rst2");
        chk("rst.count_const",  32'(count),  32'h0);
        chk("rst.decode_const", 32'(decode), 32'h0001);
        rst = 1'b0;

        // Binary up count with limit 9
        enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick("bin_up");
            chk("bin_up.count_const", 32'(count), 32'((i + 1) % 10));
            chk("bin_up.wrap_const",  32'(wrap),  32'(((i + 1) % 10) == 0));
        end

        // Gray: load 7, one up step
        enable = 1'b0; mode = 2'd1; limit = 4'd15;
        tick("gray_sw");
        load = 1'b1; load_val = 4'd7;
        tick("gray_load");
        chk("gray_load.count_const",  32'(count),  32'b0100);
        chk("gray_load.decode_const", 32'(decode), 32'h0080);
        load = 1'b0; enable = 1'b1; up_dn = 1'b1;
        tick("gray_step");
        chk("gray_step.count_const",  32'(count),  32'b1100);
        chk("gray_step.decode_const", 32'(decode), 32'h0100);

        // Johnson down from 0
        enable = 1'b0; mode = 2'd2;
        tick("john_sw");
        enable = 1'b1; up_dn = 1'b0;
        tick("john_dn1");
        chk("john_dn1.count_const", 32'(count), 32'b1000);
        chk("john_dn1.wrap_const",  32'(wrap),  32'd1);
        tick("john_dn2");
        chk("john_dn2.count_const", 32'(count), 32'b1100);

        // Rejected load, then load beats enable
        enable = 1'b0; mode = 2'd0; limit = 4'd5;
        tick("lerr_sw");
        load = 1'b1; load_val = 4'd9;
        tick("lerr_load");
        chk("lerr_load.flag_const", 32'(load_err), 32'd1);
        load = 1'b0;
        tick("lerr_clear");
        chk("lerr_clear.flag_const", 32'(load_err), 32'd0);
        load = 1'b1; load_val = 4'd3; enable = 1'b1; up_dn = 1'b1;
        tick("load_wins");
        chk("load_wins.count_const", 32'(count), 32'd3);
        load = 1'b0; enable = 1'b0;

        // Switch to ring from idx 2, then reset mid-count
        limit = 4'd9; load = 1'b1; load_val = 4'd2;
        tick("ring_pre");
        load = 1'b0; mode = 2'd3;
        tick("ring_sw");
        chk("ring_sw.count_const", 32'(count), 32'b0001);
        chk("ring_sw.wrap_const",  32'(wrap),  32'd0);
        enable = 1'b1;
        tick("ring_up1");
        tick("ring_up2");
        rst = 1'b1;
        tick("ring_rst");
        chk("ring_rst.decode_const", 32'(decode), 32'h0001);
        rst = 1'b0;

        // limit = 0: index pinned, wrap on every enabled step
        mode = 2'd0; limit = 4'd0;
        tick("lim0_sw");
        for (int i = 0; i < 3; i++) begin
            up_dn = i[0];
            tick("lim0");
            chk("lim0.wrap_const", 32'(wrap), 32'd1);
        end

        // Lowered limit below the index
        limit = 4'd9; enable = 1'b0; load = 1'b1; load_val = 4'd8;
        tick("lower_load");
        load = 1'b0; limit = 4'd3; enable = 1'b1; up_dn = 1'b0;
        tick("lower_dn");
        chk("lower_dn.count_const", 32'(count), 32'd3);
        enable = 1'b0; limit = 4'd9; load = 1'b1; load_val = 4'd8;
        tick("lower_load2");
        load = 1'b0; limit = 4'd3; enable = 1'b1; up_dn = 1'b1;
        tick("lower_up");
        chk("lower_up.wrap_const", 32'(wrap), 32'd1);

        // Random traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            rst      = ($urandom_range(0, 40) == 0);
            load     = ($urandom_range(0, 7) == 0);
            enable   = ($urandom_range(0, 3) != 0);
            up_dn    = $urandom_range(0, 1) != 0;
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) limit = 4'($urandom_range(0, 15));
            load_val = 4'($urandom_range(0, 15));
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
